// File: rtl/ucode_sequencer.sv
// ucode_sequencer
//   Microcode sequencer driven by the TState T-state counter. Latches the
//   opcode at T1, addresses the microcode ROM with {op_reg, T}, registers the
//   returned control word onto ctrl, and on an END bit (ctrl word MSB) at
//   T>=2 pulses t_reset_bar low for one clock so TState restarts at T0.
//
//   Optional build macro: UCODE_ERRCHK_EN compiles in the sticky sequence
//   checker that drives err. Without it, err is tied to 0.
//
// Ports
//   clk          in   system clock, rising edge
//   reset        in   synchronous, active-high reset
//   T            in   current T-state from TState
//   bus          in   data bus, opcode on bus[15:8]
//   udata        in   microcode ROM word for uaddr (asynchronous ROM)
//   uaddr        out  ROM address {op_reg, T}, combinational
//   ctrl         out  registered control word
//   t_reset_bar  out  to TState reset2_bar, one-clock low pulse on END
//   instr_count  out  completed-instruction counter (wraps)
//   err          out  sticky sequence error (0 unless UCODE_ERRCHK_EN)

module ucode_sequencer #(
    parameter int OPW = 8,
    parameter int CW  = 16
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [2:0]     T,
    input  logic [15:0]    bus,
    input  logic [CW-1:0]  udata,
    output logic [OPW+2:0] uaddr,
    output logic [CW-1:0]  ctrl,
    output logic           t_reset_bar,
    output logic [15:0]    instr_count,
    output logic           err
);

    typedef enum logic [1:0] {
        SYNC  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t          state, state_d;
    logic [OPW-1:0]  op_reg;
    logic [2:0]      prev_T;
    logic [CW-1:0]   ctrl_d;
    logic            trb_d;
    logic            end_ok;

    // Only the opcode byte of the bus is consumed here.
    logic unused_bus;
    assign unused_bus = ^bus[7:0];

    assign uaddr  = {op_reg, T};
    // END is honoured only past the fetch rows (T0/T1).
    assign end_ok = udata[CW-1] && (T >= 3'd2);

    always_comb begin
        state_d = state;
        ctrl_d  = '0;
        trb_d   = 1'b1;
        unique case (state)
            SYNC: begin
                if (T == 3'd0) state_d = RUN;
            end
            RUN: begin
                ctrl_d = udata;
                if (end_ok) begin
                    trb_d   = 1'b0;
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                // TState should have been cleared by the pulse; if not,
                // fall back to SYNC and wait for a clean T0.
                state_d = (T == 3'd0) ? RUN : SYNC;
            end
            default: state_d = SYNC;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= SYNC;
            op_reg      <= '0;
            ctrl        <= '0;
            t_reset_bar <= 1'b1;
            prev_T      <= 3'd0;
            instr_count <= 16'd0;
        end else begin
            state       <= state_d;
            ctrl        <= ctrl_d;
            t_reset_bar <= trb_d;
            prev_T      <= T;
            if (T == 3'd1) op_reg <= OPW'(bus[15:8]);
            // First edge that samples T0 marks a completed instruction.
            if (T == 3'd0 && prev_T != 3'd0) instr_count <= instr_count + 16'd1;
        end
    end

`ifdef UCODE_ERRCHK_EN
    logic after_flush;
    logic seq_bad;

    // The edge right after FLUSH sees a fresh T sequence, so the
    // increment check is skipped there.
    always_comb begin
        seq_bad = 1'b0;
        if (state == RUN && !after_flush && T != 3'(prev_T + 3'd1)) seq_bad = 1'b1;
        if (state == FLUSH && T != 3'd0)                            seq_bad = 1'b1;
        if (state == RUN && udata[CW-1] && T < 3'd2)                seq_bad = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            err         <= 1'b0;
            after_flush <= 1'b0;
        end else begin
            after_flush <= (state == FLUSH);
            if (seq_bad) err <= 1'b1;
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: doc/ucode_sequencer.md
# ucode_sequencer

Microcode sequencer on the consuming end of the T-state counter. It samples `T` from `TState` and latches the opcode at T1. It forms the microcode ROM address `{opcode, T}`, registers the returned control word onto the control bus, and on a microcode END bit pulses `t_reset_bar` low to restart `TState` at T0. The block sits between `TState`, the microcode ROM and the datapath control lines.

## Interface
Parameters:
- `OPW`, 8: opcode width.
- `CW`, 16: control word width; bit `CW-1` is the END flag.

Ports:
- `clk`  in  1: system clock. All state updates on rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `T`  in  3: current T-state from `TState`.
- `bus`  in  16: data bus; opcode is `bus[15:8]`.
- `udata`  in  CW: microcode ROM output for `uaddr` (asynchronous ROM).
- `uaddr`  out  OPW+3: ROM address, combinational `{op_reg, T}`.
- `ctrl`  out  CW: registered control word.
- `t_reset_bar`  out  1: to `TState` `reset2_bar`; low for one cycle restarts T at 0.
- `instr_count`  out  16: completed-instruction counter.
- `err`  out  1: sticky sequence error. Present only with `UCODE_ERRCHK_EN`; see Configuration.

## Operation
- Reset values:
  - `op_reg` = 0, `ctrl` = 0, `t_reset_bar` = 1, `instr_count` = 0, `err` = 0.
  - `prev_T` = 0, state = SYNC.
- Opcode latch: on an edge with `T==1`, `op_reg <= bus[15:8]`. `op_reg` holds at all other times.
- T0/T1 rows are identical fetch words for every opcode, so a stale `op_reg` during fetch is harmless.
- State SYNC:
  - `ctrl <= 0`.
  - On an edge with `T==0`, go to RUN.
- State RUN:
  - `ctrl <= udata` on every edge.
  - If `udata[CW-1]==1` and `T>=2`: `t_reset_bar <= 0`, go to FLUSH.
  - END with `T<2` is ignored.
  - No END by `T==7`: `TState` wraps naturally to 0; stay in RUN.
- State FLUSH:
  - `t_reset_bar <= 1`, `ctrl <= 0` (one bubble cycle).
  - Next edge: if `T==0`, go to RUN; otherwise go to SYNC.
- `prev_T <= T` every edge.
- `instr_count`: increments on an edge where `T==0 && prev_T!=0`, in any state. Wraps 0xFFFF→0x0000.
- `reset` asserted mid-instruction wins over every other action. `t_reset_bar` returns to 1 in the same edge.

## Timing
- `uaddr` is combinational from `op_reg` and `T`. The ROM path must settle within one clock.
- `ctrl` latency: one rising edge after `uaddr` changes.
- END decode to `t_reset_bar` low: registered, asserts at the edge that samples END. Pulse width is exactly one clock.
- Opcode is visible in `uaddr` from the edge after the T1 sample, i.e. in time for T2.
- Back-to-back instructions: END, then FLUSH bubble, then RUN resumes with the T0 fetch word. Minimum instruction length is 3 RUN cycles plus 1 bubble.
- `instr_count` updates on the same edge that first samples T0.

## Configuration
`UCODE_ERRCHK_EN` compiles in the sequence checker.

Defined:
- `err` sets, and stays set until `reset`, on any of:
  - In RUN, `T != prev_T+1 (mod 8)`, excluding the edge after FLUSH.
  - In FLUSH, `T != 0` on the following edge.
  - END seen in RUN with `T<2`.

Undefined:
- `err` is a constant 0.
- No checker logic is built.

## Test plan
- Reset, then `T` walks 0→7→0 with all-zero `udata` → `ctrl` = 0 throughout; `instr_count` = 1 after the wrap; `err` = 0.
- `bus = 0x3A00` at T1 → `uaddr` = {0x3A, 3'd2} at T2; `udata = 0x1234` at T2 → `ctrl` = 0x1234 one edge later.
- `udata = 0x8005` at T3 → `t_reset_bar` low for exactly 1 cycle; next `ctrl` = 0 (bubble); `T` forced to 0; back to RUN; `instr_count` +1.
- END at T1 → no `t_reset_bar` pulse; with `UCODE_ERRCHK_EN`, `err` = 1 and held until `reset`.
- With `UCODE_ERRCHK_EN`, `T` jumps 2→5 → `err` = 1. Without the macro, the same stimulus leaves `err` = 0.
- `reset` asserted at T4 mid-instruction with `instr_count` = 0xFFFF → all outputs return to reset values on that edge. A separate run from 0xFFFF wraps to 0x0000 on the next T0.
